// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: command-driven LED sequencer (off / steady / blink / burst).
// Every timed phase lasts TICK_DIV cycles of CLK, counted by an internal prescaler.
// Optional build macro LED_PWM_EN adds the PWM_DUTY input, which dims the LED
// with an 8-bit free-running PWM counter.
//
// state       | meaning
// ------------+-------------------------------------------------
// S_IDLE      | LED off, ready for commands
// S_STEADY    | LED on continuously
// S_BLINK_ON  | continuous blink, on phase
// S_BLINK_OFF | continuous blink, off phase
// S_BURST_ON  | finite burst, on phase (commands blocked)
// S_BURST_OFF | finite burst, off phase (commands blocked)
module led_pattern_ctrl #(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_MODE,
  input  logic [CNT_W-1:0] CMD_COUNT,
`ifdef LED_PWM_EN
  input  logic [7:0]       PWM_DUTY,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic             LED
);

  localparam int             PS_W    = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STEADY, S_BLINK_ON, S_BLINK_OFF, S_BURST_ON, S_BURST_OFF
  } state_t;

  state_t           state, state_nxt;
  logic [PS_W-1:0]  prescaler, prescaler_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic             done_nxt;
  logic             led_phase;
  logic             accept, timed, tick;

  assign accept = CMD_VALID & CMD_READY;
  assign timed  = (state == S_BLINK_ON) || (state == S_BLINK_OFF) ||
                  (state == S_BURST_ON) || (state == S_BURST_OFF);
  assign tick   = timed && (prescaler == PS_LAST);

  // Next-state, prescaler and burst bookkeeping; an accept overrides any tick.
  always_comb begin
    state_nxt     = state;
    prescaler_nxt = '0;
    remaining_nxt = remaining;
    done_nxt      = 1'b0;
    if (accept) begin
      case (CMD_MODE)
        2'b00: state_nxt = S_IDLE;
        2'b01: state_nxt = S_STEADY;
        2'b10: state_nxt = S_BLINK_ON;
        default: begin
          if (CMD_COUNT != '0) begin
            state_nxt     = S_BURST_ON;
            remaining_nxt = CMD_COUNT;
          end else begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end
        end
      endcase
    end else begin
      if (timed) prescaler_nxt = tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        case (state)
          S_BLINK_ON:  state_nxt = S_BLINK_OFF;
          S_BLINK_OFF: state_nxt = S_BLINK_ON;
          S_BURST_ON:  state_nxt = S_BURST_OFF;
          S_BURST_OFF: begin
            if (remaining == CNT_W'(1)) begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
            end else begin
              remaining_nxt = remaining - 1'b1;
              state_nxt     = S_BURST_ON;
            end
          end
          default: state_nxt = state;
        endcase
      end
    end
  end

  // State registers; outputs are decoded from the next state so they track state exactly.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      prescaler <= '0;
      remaining <= '0;
      led_phase <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      CMD_READY <= 1'b1;
    end else begin
      state     <= state_nxt;
      prescaler <= prescaler_nxt;
      remaining <= remaining_nxt;
      led_phase <= (state_nxt == S_STEADY) || (state_nxt == S_BLINK_ON) ||
                   (state_nxt == S_BURST_ON);
      BUSY      <= (state_nxt != S_IDLE);
      DONE      <= done_nxt;
      CMD_READY <= !((state_nxt == S_BURST_ON) || (state_nxt == S_BURST_OFF));
    end
  end

`ifdef LED_PWM_EN
  logic [7:0] pwm_cnt;

  // Free-running PWM counter; LED is on while the counter is below the duty value.
  always_ff @(posedge CLK) begin
    if (!RST_N) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign LED = led_phase & (pwm_cnt < PWM_DUTY);
`else
  assign LED = led_phase;
`endif

endmodule
